// File: rtl/led_status_driver.sv
// rtl/led_status_driver.sv - registered LED status driver: thermometer bar, stretched flags, blink and lamp test
module led_status_driver #(
    parameter int          LED_W        = 16,
    parameter int          BAR_W        = 8,
    parameter int          FLAG_W       = 5,
    parameter int          VAL_W        = 4,
    parameter int          STRETCH      = 15,
    parameter logic [FLAG_W-1:0] STRETCH_MASK = 5'b00110,
    parameter int          BLINK_HALF   = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VAL_W-1:0]  bar_value,
    input  logic [FLAG_W-1:0] flags,
    input  logic              blink_en,
    input  logic              lamp_test,
    output logic [LED_W-1:0]  led
);

    localparam int SCNT_W = (STRETCH > 1) ? $clog2(STRETCH + 1) : 1;
    localparam int BCNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STRETCH);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF - 1);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [SCNT_W-1:0] scnt_q [FLAG_W];
    logic [SCNT_W-1:0] scnt_d [FLAG_W];
    logic [LED_W-1:0]  led_q, led_d;

    logic [FLAG_W-1:0] flag_vis;
    logic [BAR_W-1:0]  bar_img;
    logic [LED_W-1:0]  img;

    // Free-running blink timebase; blink_en only gates, never restarts it.
    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Stretch counters keep running under lamp test and blink-off, so the hold is not extended.
    always_comb begin
        for (int i = 0; i < FLAG_W; i++) begin
            scnt_d[i]   = '0;
            flag_vis[i] = flags[i];
            if (STRETCH_MASK[i]) begin
                if (flags[i]) begin
                    scnt_d[i] = SCNT_LOAD;
                end else if (scnt_q[i] != '0) begin
                    scnt_d[i] = scnt_q[i] - 1'b1;
                end
                flag_vis[i] = flags[i] | (scnt_q[i] != '0);
            end
        end
    end

    always_comb begin
        bar_img = '0;
        if (int'(bar_value) > BAR_W) begin
            bar_img = {BAR_W{phase_q}};
        end else begin
            for (int k = 0; k < BAR_W; k++) begin
                bar_img[k] = (k < int'(bar_value));
            end
        end
    end

    always_comb begin
        img                     = '0;
        img[BAR_W-1:0]          = bar_img;
        img[LED_W-1 -: FLAG_W]  = flag_vis;
        if (lamp_test) begin
            led_d = '1;
        end else if (blink_en) begin
            led_d = img & {LED_W{phase_q}};
        end else begin
            led_d = img;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            led_q   <= '0;
            for (int i = 0; i < FLAG_W; i++) begin
                scnt_q[i] <= '0;
            end
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            for (int i = 0; i < FLAG_W; i++) begin
                scnt_q[i] <= scnt_d[i];
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_status_driver.sv
// tb/tb_led_status_driver.sv - randomized self-checking bench for led_status_driver
module tb_led_status_driver;

    localparam int S  = 3;
    localparam int BH = 4;
    localparam logic [4:0] MASK = 5'b00110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  bar_value = '0;
    logic [4:0]  flags = '0;
    logic        blink_en = 1'b0;
    logic        lamp_test = 1'b0;
    logic [15:0] led;

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    int          last_hi [5];
    logic [15:0] exp_led;

    led_status_driver #(
        .LED_W(16), .BAR_W(8), .FLAG_W(5), .VAL_W(4),
        .STRETCH(S), .STRETCH_MASK(MASK), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bar_value(bar_value), .flags(flags),
        .blink_en(blink_en), .lamp_test(lamp_test), .led(led)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 5; i++) last_hi[i] = -1000;
    endtask

    // Drive inputs, take one edge, compute expected led from the stated rules.
    task automatic step(input logic [3:0] bv, input logic [4:0] fl, input logic bl, input logic lt);
        logic        ph;
        logic [15:0] im;
        bar_value = bv; flags = fl; blink_en = bl; lamp_test = lt;
        @(posedge clk);
        n++;
        ph = ((((n - 1) / BH) % 2) == 0);
        for (int i = 0; i < 5; i++) if (fl[i]) last_hi[i] = n;
        im = '0;
        if (int'(bv) > 8) im[7:0] = {8{ph}};
        else for (int k = 0; k < int'(bv); k++) im[k] = 1'b1;
        for (int i = 0; i < 5; i++)
            im[11+i] = MASK[i] ? ((n - last_hi[i]) <= S) : fl[i];
        if (lt)      exp_led = 16'hFFFF;
        else if (bl) exp_led = im & {16{ph}};
        else         exp_led = im;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        lamp_test = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led !== 16'hFFFF) begin errors++; $display("FAIL pre_reset_lamp led=%h exp=%h", led, 16'hFFFF); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 16'h0000) begin errors++; $display("FAIL async_reset led=%h exp=%h", led, 16'h0000); end
        lamp_test = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_bar();
        logic [3:0]  vals [3] = '{4'd3, 4'd8, 4'd0};
        logic [15:0] req  [3] = '{16'h0007, 16'h00FF, 16'h0000};
        for (int j = 0; j < 3; j++) begin
            step(vals[j], 5'b0, 1'b0, 1'b0);
            checks++;
            if (led !== req[j]) begin errors++; $display("FAIL bar_%0d led=%h exp=%h", vals[j], led, req[j]); end
        end
    endtask

    task automatic test_overflow_blink();
        do_reset();
        for (int j = 0; j < 16; j++) begin
            step(4'd12, 5'b0, 1'b0, 1'b0);
            checks++;
            if (led[7:0] !== (((j / 4) % 2 == 0) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL overflow_bar cyc=%0d led=%h", j, led);
            end
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL overflow_model cyc=%0d led=%h exp=%h", j, led, exp_led); end
        end
    endtask

    task automatic test_stretch();
        int cnt;
        cnt = 0;
        step(4'd0, 5'b00010, 1'b0, 1'b0);
        if (led[12]) cnt++;
        for (int j = 0; j < 8; j++) begin
            step(4'd0, 5'b0, 1'b0, 1'b0);
            if (led[12]) cnt++;
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL stretch_model led=%h exp=%h", led, exp_led); end
        end
        checks++;
        if (cnt != S + 1) begin errors++; $display("FAIL stretch_single cycles=%0d exp=%0d", cnt, S + 1); end
        cnt = 0;
        step(4'd0, 5'b00010, 1'b0, 1'b0); if (led[12]) cnt++;
        step(4'd0, 5'b00000, 1'b0, 1'b0); if (led[12]) cnt++;
        step(4'd0, 5'b00010, 1'b0, 1'b0); if (led[12]) cnt++;
        for (int j = 0; j < 8; j++) begin
            step(4'd0, 5'b0, 1'b0, 1'b0);
            if (led[12]) cnt++;
        end
        checks++;
        if (cnt != S + 3) begin errors++; $display("FAIL stretch_retrigger cycles=%0d exp=%0d", cnt, S + 3); end
        cnt = 0;
        step(4'd0, 5'b00001, 1'b0, 1'b0); if (led[11]) cnt++;
        for (int j = 0; j < 6; j++) begin
            step(4'd0, 5'b0, 1'b0, 1'b0);
            if (led[11]) cnt++;
        end
        checks++;
        if (cnt != 1) begin errors++; $display("FAIL unstretched cycles=%0d exp=1", cnt); end
    endtask

    task automatic test_priority();
        for (int j = 0; j < 10; j++) begin
            step(4'd5, 5'b10101, 1'b1, 1'b1);
            checks++;
            if (led !== 16'hFFFF) begin errors++; $display("FAIL lamp_over_blink led=%h exp=%h", led, 16'hFFFF); end
        end
        for (int j = 0; j < 10; j++) begin
            step(4'd5, 5'b10101, 1'b1, 1'b0);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL blink_after_lamp led=%h exp=%h", led, exp_led); end
        end
    endtask

    task automatic test_reset_mid_stretch();
        step(4'd0, 5'b00010, 1'b0, 1'b0);
        step(4'd0, 5'b00000, 1'b0, 1'b0);
        checks++;
        if (led[12] !== 1'b1) begin errors++; $display("FAIL mid_stretch_bit led12=%b exp=1", led[12]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 16'h0000) begin errors++; $display("FAIL mid_stretch_reset led=%h exp=0000", led); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < 5; j++) begin
            step(4'd0, 5'b0, 1'b0, 1'b0);
            checks++;
            if (led !== 16'h0000) begin errors++; $display("FAIL no_residual_hold led=%h exp=0000", led); end
        end
    endtask

    // Park so that the next edge sits at position pos within the 2*BH blink period.
    task automatic align(input int pos);
        for (int g = 0; g < 2 * BH && (n % (2 * BH)) != pos; g++)
            step(4'd0, 5'b0, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        int cnt;
        int want [2] = '{0, S};
        int pos  [2] = '{BH, 2 * BH - 1};
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 8; j++) step(4'd0, 5'b0, 1'b1, 1'b0);
            align(pos[c]);
            step(4'd0, 5'b00100, 1'b1, 1'b0);
            checks++;
            if (led[13] !== 1'b0) begin errors++; $display("FAIL sim_hidden case=%0d led13=%b exp=0", c, led[13]); end
            for (int j = 0; j < 2 * BH - 1 - pos[c] + 1 - 1; j++) step(4'd0, 5'b0, 1'b1, 1'b0);
            cnt = 0;
            for (int j = 0; j < BH; j++) begin
                step(4'd0, 5'b0, 1'b1, 1'b0);
                if (led[13]) cnt++;
                checks++;
                if (led !== exp_led) begin errors++; $display("FAIL sim_model case=%0d led=%h exp=%h", c, led, exp_led); end
            end
            checks++;
            if (cnt != want[c]) begin errors++; $display("FAIL sim_visible case=%0d cycles=%0d exp=%0d", c, cnt, want[c]); end
        end
    endtask

    task automatic test_random();
        logic [4:0] fl;
        for (int j = 0; j < 400; j++) begin
            fl = 5'($urandom) & 5'($urandom);
            step(4'($urandom_range(0, 15)), fl, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL random cyc=%0d led=%h exp=%h", j, led, exp_led); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bar();
        test_overflow_blink();
        test_stretch();
        test_priority();
        test_reset_mid_stretch();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_driver.md
# led_status_driver

Registered, parametrised successor to the Flood-It board LED status display. It drives a thermometer bar for a small value, such as the selected colour count. It also drives a group of status flags, with per-flag pulse stretching so that single-cycle handshakes (begin/ack/init strobes) remain visible. Blink and lamp-test modes complete the block. It sits between the game FSMs and the board LED pins.

## Interface
Parameters:
- LED_W, 16: total LED outputs.
- BAR_W, 8: thermometer bar width, occupying led[BAR_W-1:0].
- FLAG_W, 5: flag count, occupying led[LED_W-1 -: FLAG_W]; BAR_W+FLAG_W <= LED_W is required.
- VAL_W, 4: width of bar_value.
- STRETCH, 15: extra hold cycles for stretched flags; must be >= 1.
- STRETCH_MASK, 5'b00110: bit i=1 means flag i is pulse-stretched.
- BLINK_HALF, 25_000_000: cycles per blink half-period; must be >= 1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- bar_value, in, VAL_W: number of bar LEDs to light.
- flags, in, FLAG_W: status flag levels or strobes.
- blink_en, in, 1: blink the whole display.
- lamp_test, in, 1: force all LEDs on.
- led, out, LED_W: registered LED drive.

## Operation
- Bar:
  - lit = min(bar_value, BAR_W); led[k] = 1 for k < lit, else 0.
  - bar_value = 0 lights no bar LEDs.
  - If bar_value > BAR_W (overflow), all BAR_W bits = phase.
- Gap bits led[LED_W-FLAG_W-1:BAR_W] are always 0.
- Flags:
  - Unstretched flag i: led bit = flags[i].
  - Stretched flag i has its own down-counter scnt_i, range 0..STRETCH.
  - Counter update: flags[i]=1 loads STRETCH (retrigger restarts the hold); otherwise a nonzero scnt_i decrements.
  - Displayed bit = flags[i] | (scnt_i != 0).
- Blink generator:
  - bcnt counts 0..BLINK_HALF-1 and wraps.
  - phase toggles on the cycle bcnt == BLINK_HALF-1.
  - Free-running from reset; it is not restarted by blink_en.
- Output priority, evaluated each cycle:
  1. lamp_test=1: led <= all ones.
  2. Else blink_en=1: led <= normal image AND {LED_W{phase}}.
  3. Else: led <= normal image.
- Simultaneous events: a flag strobe during lamp_test or a blink-off phase still loads its stretch counter. The hold time therefore continues underneath and is not extended.

## Timing
- Reset (rst_n=0, asynchronous): led=0, all scnt=0, bcnt=0, phase=1. Takes effect immediately, including mid-stretch or mid-blink.
- Latency: led reflects inputs sampled at edge t on the output after edge t (1 cycle). There is no combinational input-to-output path.
- Stretched single-cycle strobe sampled at edge t: led bit is 1 after edges t..t+STRETCH (STRETCH+1 cycles) and 0 after edge t+STRETCH+1.
- Stretched level held high for N cycles: bit stays high for N+STRETCH cycles.
- Unstretched flag: follows its input with 1-cycle delay; no stretching.
- Blink after reset release:
  - Outputs from edges 1..BLINK_HALF use phase=1 (on).
  - Edges BLINK_HALF+1..2·BLINK_HALF use phase=0 (off).
  - The pattern then repeats with period 2·BLINK_HALF.
- Overflow bar and blink_en use the same phase, so they are always in step.
- Input changes mid-blink take effect on the next edge, gated by the current phase.

## Test plan
Default parameters unless stated.
- Reset/bar:
  - Assert rst_n=0 -> led=16'h0000 asynchronously.
  - Release reset, set bar_value=3, flags=0 -> led=16'h0007 one cycle later.
  - bar_value=8 -> 16'h00FF; bar_value=0 -> 16'h0000.
- Overflow blink (BLINK_HALF=4), bar_value=12:
  - led[7:0] = 8'hFF for 4 cycles, then 8'h00 for 4 cycles, repeating.
  - led[15:8] = 0 throughout.
- Stretch (STRETCH=3):
  - One-cycle pulse on flags[1] -> led[12]=1 for exactly 4 cycles.
  - Second pulse 2 cycles after the first -> hold extends to 4 cycles past the second pulse.
  - Same one-cycle pulse on flags[0] -> led[11]=1 for exactly 1 cycle.
- Priority:
  - lamp_test=1 with blink_en=1 -> led=16'hFFFF steadily.
  - Release lamp_test -> normal image gated by phase.
- Reset mid-stretch (STRETCH=3): assert rst_n during a stretch -> led=0 immediately; after release the flag bit stays 0 with no residual hold.
- Simultaneous (STRETCH=3): pulse flags[2] while blink phase=0 -> bit hidden during off-phase; visible in the next on-phase only if fewer than 4 cycles have elapsed since the pulse.
